// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, one-hot ALU, data-SRAM request,
// HI/LO registers with single-cycle multiply and a 32-step restoring divider.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_ID_WD  = 38,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    ex_is_load,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------- ID/EX register ----------------
    logic [ID_TO_EX_WD-1:0] ex_bus_q, ex_bus_d;

    // Bubble when EX stops but MEM keeps going, load when EX advances, else hold
    always_comb begin
        ex_bus_d = ex_bus_q;
        if (stall[2] && !stall[3]) ex_bus_d = '0;
        else if (!stall[2])        ex_bus_d = id_to_ex_bus;
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en, rf_we, sel_rf_res;
    logic [3:0]  data_ram_wen;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en,
            data_ram_wen, rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = ex_bus_q;

    // ---------------- ALU ----------------
    logic [31:0] src1, src2, alu_res, sra_res;
    logic [4:0]  sh;

    assign src1 = ({32{sel_alu_src1[0]}} & rdata1)
                | ({32{sel_alu_src1[1]}} & pc)
                | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});

    assign src2 = ({32{sel_alu_src2[0]}} & rdata2)
                | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_alu_src2[2]}} & 32'd8)
                | ({32{sel_alu_src2[3]}} & {16'b0, inst[15:0]});

    assign sh      = src1[4:0];
    assign sra_res = $signed(src2) >>> sh;

    // alu_op bit 11 is add down to bit 0 lui
    assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                   | ({32{alu_op[10]}} & (src1 - src2))
                   | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src2 << sh))
                   | ({32{alu_op[2]}}  & (src2 >> sh))
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

    // ---------------- HI/LO decode ----------------
    logic is_special, is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic is_mult, is_multu, is_div_s, is_div_u, is_div;

    assign is_special = (inst[31:26] == 6'h00);
    assign is_mfhi    = is_special && (inst[5:0] == 6'h10);
    assign is_mthi    = is_special && (inst[5:0] == 6'h11);
    assign is_mflo    = is_special && (inst[5:0] == 6'h12);
    assign is_mtlo    = is_special && (inst[5:0] == 6'h13);
    assign is_mult    = is_special && (inst[5:0] == 6'h18);
    assign is_multu   = is_special && (inst[5:0] == 6'h19);
    assign is_div_s   = is_special && (inst[5:0] == 6'h1A);
    assign is_div_u   = is_special && (inst[5:0] == 6'h1B);
    assign is_div     = is_div_s || is_div_u;

    logic [63:0] mul_s, mul_u;
    assign mul_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
    assign mul_u = {32'b0, rdata1} * {32'b0, rdata2};

    // ---------------- divider + HI/LO state ----------------
    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    // Divider runs on magnitudes; signs are remembered and applied once at the end
    logic [31:0] dvd_abs, dvs_abs, q_fix, r_fix;
    logic [32:0] rem_sh;
    logic        rem_ge;

    assign dvd_abs = (is_div_s && rdata1[31]) ? -rdata1 : rdata1;
    assign dvs_abs = (is_div_s && rdata2[31]) ? -rdata2 : rdata2;
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_ge  = (rem_sh >= {1'b0, dvsr_q});
    assign q_fix   = q_neg_q ? -quo_q : quo_q;
    assign r_fix   = r_neg_q ? -rem_q : rem_q;

    // Divider sequencing and all HI/LO writes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (is_mthi) hi_d = rdata1;
        if (is_mtlo) lo_d = rdata1;
        if (is_mult)  {hi_d, lo_d} = mul_s;
        if (is_multu) {hi_d, lo_d} = mul_u;

        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dvd_abs;
                    dvsr_d  = dvs_abs;
                    q_neg_d = is_div_s && (rdata1[31] ^ rdata2[31]);
                    r_neg_d = is_div_s && rdata1[31];
                end
            end
            S_RUN: begin
                // Divisor of zero always "fits", giving all-ones quotient
                if (rem_ge) begin
                    rem_d = rem_sh[31:0] - dvsr_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: begin
                // Commit only when EX advances so a held pipeline never restarts
                if (!stall[2]) begin
                    hi_d    = r_fix;
                    lo_d    = q_fix;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bus_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            ex_bus_q <= ex_bus_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // ---------------- outputs ----------------
    logic [31:0] ex_result;
    assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

    assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_id_bus    = {rf_we, rf_waddr, ex_result};
    assign ex_is_load      = sel_rf_res;
    assign data_sram_en    = data_ram_en;
    assign data_sram_wen   = data_ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;
    assign stallreq_for_ex = (state_q == S_RUN) || (state_q == S_IDLE && is_div);

    logic unused_bits;
    assign unused_bits = ^{stall[STALL_WD-1:4], stall[1:0], inst[25:16]};

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, the consumer of the decode stage's `id_to_ex_bus`. It holds the ID/EX pipeline register and evaluates the one-hot ALU operation. It issues the data-SRAM request for loads and stores, and owns the HI/LO registers: single-cycle MULT/MULTU and a 32-iteration DIV/DIVU state machine that stalls the pipeline through `stallreq_for_ex`. It drives the forwarding bus back to decode and the pipeline bus forward to MEM.

## Interface
- `ID_TO_EX_WD`, 159: input bus width. Field layout: pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0].
- `EX_TO_MEM_WD`, 76: output bus {pc 32, data_ram_en 1, data_ram_wen 4, sel_rf_res 1, rf_we 1, rf_waddr 5, ex_result 32}.
- `EX_TO_ID_WD`, 38: forwarding bus {rf_we 1, rf_waddr 5, ex_result 32}.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in `StallBus`: bit 2 controls the EX register, bit 3 controls MEM.
- `id_to_ex_bus` in 159: from decode.
- `ex_to_mem_bus` out 76: to MEM.
- `ex_to_id_bus` out 38: forwarding to decode.
- `ex_is_load` out 1: sel_rf_res of the current EX instruction, for load-use stall detection.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32: data SRAM request.
- `stallreq_for_ex` out 1: divider busy.

## Operation
- ID/EX register update, in priority order:
  - `rst`: clear to 0.
  - stall[2]=Stop and stall[3]=NoStop: clear to 0 (bubble).
  - stall[2]=NoStop: load `id_to_ex_bus`.
  - Otherwise: hold.
- src1 is one-hot selected by sel_alu_src1:
  - [0] rdata1.
  - [1] pc.
  - [2] zero-extended inst[10:6].
  - No bit set: 0.
- src2 is one-hot selected by sel_alu_src2:
  - [0] rdata2.
  - [1] sign-extended inst[15:0].
  - [2] 32'd8.
  - [3] zero-extended inst[15:0].
  - No bit set: 0.
- alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}:
  - add and sub wrap mod 2^32; no overflow trap.
  - slt compares signed, sltu compares unsigned; result is 0 or 1.
  - Shifts shift src2 by src1[4:0].
  - lui gives {src2[15:0], 16'b0}.
  - All-zero alu_op gives 0.
- HI/LO instructions are decoded from inst with opcode 0 and func:
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- ex_result is HI for MFHI, LO for MFLO, otherwise the ALU result.
- MTHI/MTLO write rdata1 to HI/LO. MULT/MULTU write the signed/unsigned 64-bit product to {HI, LO}. These writes happen at the clock edge whenever the instruction is in EX and no reset; repeated writes while stalled are harmless.
- SRAM request:
  - data_sram_en = data_ram_en.
  - data_sram_wen = data_ram_wen.
  - data_sram_addr = ALU result.
  - data_sram_wdata = rdata2.
- Divider states:
  - IDLE: a DIV/DIVU in EX latches |rs| and |rt| (signed) or raw values (unsigned), clears the counter, goes to RUN. stallreq is high in this cycle.
  - RUN: one restoring shift-subtract step per cycle. stallreq stays high. After step 32 the state goes to DONE.
  - DONE: stallreq is low. HI is written with the remainder and LO with the quotient at the edge where stall[2]=NoStop, then the state returns to IDLE. If stall[2]=Stop because of another requester, the state stays in DONE and the division is not restarted.
- Sign fix-up: quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Divide by zero is not trapped:
  - DIVU: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV: the same raw result, then the sign fix-up.
- `rst` mid-division forces IDLE, clears HI/LO to 0, and drops stallreq in the following cycle.

## Timing
- Reset values: all outputs 0, HI/LO 0, divider IDLE.
- ALU and SRAM outputs are combinational from the EX register; results reach MEM one cycle after entering EX.
- DIV/DIVU latency:
  - Cycle 0: IDLE detect.
  - Cycles 1–32: RUN.
  - Cycle 33: DONE.
  - stallreq is high for exactly 33 cycles. HI/LO are visible to an MFHI/MFLO entering EX in cycle 34.
- MULT followed immediately by MFLO returns the new LO with no stall.

## Test plan
- addiu with rdata1=0x7FFFFFFF, imm=0x0001 -> ex_result 0x80000000. The forwarding bus carries rf_we=1, the correct waddr, and the same value in the same cycle.
- Store with data_ram_wen=0xF, rdata1=0x1000, imm=0xFFFC, rdata2=0xDEADBEEF -> addr 0x00000FFC, wdata 0xDEADBEEF, en=1, wen=0xF.
- DIV -7/2 -> stallreq high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A following MFHI returns 0xFFFFFFFF.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. MULT 0xFFFFFFFF×2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- External stall[2]=Stop held 4 cycles while in DONE -> no restart, stallreq stays low, a single HI/LO write on release.
- rst asserted at RUN step 10 -> IDLE, HI/LO=0, all outputs 0 in the next cycle.
